// File: rtl/rd_stage_sequencer.sv
// ---------------------------------------------------------------------------
// rd_stage_sequencer
//
// Produces the 4-bit rd_stage code that drives the per-unit stage decoders.
// A run is a forward pass over every layer (codes 1,2,3,4 per layer). In
// training mode it continues with a backward pass over the same layers in
// reverse order (codes 5,6,9,10 per layer). Codes 9 and 10 carry the
// activation-derivative select bit (bit 3) for the decoders. Each stage is
// held for a programmable number of beats, and a datapath stall freezes
// the whole sequence.
//
// Handshake: start is a level request that is honoured only in IDLE. On the
// accepting edge, mode, num_layers and beats are captured. Requests in any
// other state are dropped. done is a one-cycle pulse with no back-pressure.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   start       launch request (sampled only in IDLE)
//   mode        0 = inference (forward only), 1 = training (forward + backward)
//   num_layers  layer count, captured at start
//   beats       cycles per stage, captured at start (0 behaves as 1)
//   stall       freezes counter, rd_stage and layer_idx while high
//   rd_stage    current stage code (registered)
//   layer_idx   layer being processed (registered)
//   stage_first high on the first beat of a stage
//   stage_last  high on the last beat of a stage
//   busy        high while a stage code is being presented
//   done        one-cycle completion pulse
// ---------------------------------------------------------------------------
module rd_stage_sequencer #(
    parameter int CNT_W   = 8,
    parameter int LAYER_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [LAYER_W-1:0] num_layers,
    input  logic [CNT_W-1:0]   beats,
    input  logic               stall,
    output logic [3:0]         rd_stage,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               stage_first,
    output logic               stage_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [3:0]         stage_n;
    logic [LAYER_W-1:0] layer_n;
    logic [CNT_W-1:0]   count, count_n;

    // Values captured at the accepting start edge.
    logic               mode_q;
    logic [LAYER_W-1:0] last_layer_q;   // num_layers - 1
    logic [CNT_W-1:0]   beat_max_q;     // B - 1, with beats==0 treated as B=1

    logic               accept;
    logic               at_last_beat;

    assign accept       = (state == IDLE) && start;
    assign at_last_beat = (count == beat_max_q);

    assign busy        = (state == FWD) || (state == BWD);
    assign done        = (state == FIN);
    assign stage_first = busy && (count == '0);
    assign stage_last  = busy && at_last_beat;

    // Next-state, next-stage and next-counter decode.
    always_comb begin
        state_n = state;
        stage_n = rd_stage;
        layer_n = layer_idx;
        count_n = count;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_layers == '0) begin
                        state_n = FIN;
                    end else begin
                        state_n = FWD;
                        stage_n = 4'd1;
                        layer_n = '0;
                        count_n = '0;
                    end
                end
            end
            FWD: begin
                if (!stall) begin
                    if (!at_last_beat) begin
                        count_n = count + 1'b1;
                    end else begin
                        count_n = '0;
                        case (rd_stage)
                            4'd1: stage_n = 4'd2;
                            4'd2: stage_n = 4'd3;
                            4'd3: stage_n = 4'd4;
                            default: begin
                                if (layer_idx == last_layer_q) begin
                                    if (mode_q) begin
                                        // Backward pass starts at the last layer.
                                        state_n = BWD;
                                        stage_n = 4'd5;
                                        layer_n = last_layer_q;
                                    end else begin
                                        state_n = FIN;
                                        stage_n = 4'd0;
                                        layer_n = '0;
                                    end
                                end else begin
                                    stage_n = 4'd1;
                                    layer_n = layer_idx + 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            BWD: begin
                if (!stall) begin
                    if (!at_last_beat) begin
                        count_n = count + 1'b1;
                    end else begin
                        count_n = '0;
                        case (rd_stage)
                            4'd5: stage_n = 4'd6;
                            4'd6: stage_n = 4'd9;
                            4'd9: stage_n = 4'd10;
                            default: begin
                                if (layer_idx == '0) begin
                                    state_n = FIN;
                                    stage_n = 4'd0;
                                end else begin
                                    stage_n = 4'd5;
                                    layer_n = layer_idx - 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            default: begin  // FIN: single cycle, start here is dropped
                state_n = IDLE;
                stage_n = 4'd0;
                layer_n = '0;
                count_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rd_stage     <= 4'd0;
            layer_idx    <= '0;
            count        <= '0;
            mode_q       <= 1'b0;
            last_layer_q <= '0;
            beat_max_q   <= '0;
        end else begin
            state     <= state_n;
            rd_stage  <= stage_n;
            layer_idx <= layer_n;
            count     <= count_n;
            if (accept) begin
                mode_q       <= mode;
                last_layer_q <= num_layers - 1'b1;
                beat_max_q   <= (beats == '0) ? '0 : beats - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rd_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rd_stage_sequencer
//
// Directed bench for rd_stage_sequencer. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled at the same point, so "cycle N"
// means the register values following the N-th rising edge after start was
// presented. Each task drives one scenario and checks the packed observation
// {rd_stage, layer_idx, stage_first, stage_last, busy, done} against values
// computed here.
// ---------------------------------------------------------------------------
module tb_rd_stage_sequencer;

    localparam int CNT_W   = 8;
    localparam int LAYER_W = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic               mode;
    logic [LAYER_W-1:0] num_layers;
    logic [CNT_W-1:0]   beats;
    logic               stall;
    logic [3:0]         rd_stage;
    logic [LAYER_W-1:0] layer_idx;
    logic               stage_first;
    logic               stage_last;
    logic               busy;
    logic               done;

    int checks;
    int passes;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rd_stage_sequencer #(
        .CNT_W  (CNT_W),
        .LAYER_W(LAYER_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .num_layers (num_layers),
        .beats      (beats),
        .stall      (stall),
        .rd_stage   (rd_stage),
        .layer_idx  (layer_idx),
        .stage_first(stage_first),
        .stage_last (stage_last),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents start for one cycle; returns at cycle 1.
    task automatic launch(input logic m, input int nl, input int b);
        mode       = m;
        num_layers = LAYER_W'(nl);
        beats      = CNT_W'(b);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [11:0] obs;
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; num_layers = '0; beats = '0; stall = 1'b0;
        repeat (3) tick();
        obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
        checks++;
        if (obs !== 12'h000)
            $display("FAIL reset_state obs=%h exp=%h", obs, 12'h000);
        else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_inference();
        logic [11:0] obs, exp;
        launch(1'b0, 2, 3);
        for (int c = 1; c <= 24; c++) begin
            exp = {4'(((c - 1) % 12) / 3 + 1), 4'((c - 1) / 12),
                   ((c - 1) % 3 == 0), ((c - 1) % 3 == 2), 1'b1, 1'b0};
            obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
            checks++;
            if (obs !== exp)
                $display("FAIL inference cycle=%0d obs=%h exp=%h", c, obs, exp);
            else passes++;
            tick();
        end
        obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
        checks++;
        if (obs !== 12'h001)
            $display("FAIL inference_done cycle=25 obs=%h exp=%h", obs, 12'h001);
        else passes++;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL inference_idle done=%b busy=%b exp=0/0", done, busy);
        else passes++;
    endtask

    task automatic test_training(input int b);
        logic [11:0] obs, exp;
        int st [16];
        int ly [16];
        st = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 9, 10, 5, 6, 9, 10};
        ly = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        launch(1'b1, 2, b);
        for (int c = 1; c <= 16; c++) begin
            exp = {4'(st[c-1]), 4'(ly[c-1]), 1'b1, 1'b1, 1'b1, 1'b0};
            obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
            checks++;
            if (obs !== exp)
                $display("FAIL training_b%0d cycle=%0d obs=%h exp=%h", b, c, obs, exp);
            else passes++;
            tick();
        end
        checks++;
        if (rd_stage !== 4'd0 || busy !== 1'b0 || done !== 1'b1)
            $display("FAIL training_b%0d_done stage=%0d busy=%b done=%b exp=0/0/1",
                     b, rd_stage, busy, done);
        else passes++;
        tick();
        checks++;
        if (done !== 1'b0)
            $display("FAIL training_b%0d_pulse done=%b exp=0", b, done);
        else passes++;
    endtask

    task automatic test_stall();
        logic [11:0] obs, exp;
        int st [11];
        int fi [11];
        int la [11];
        st = '{1, 1, 2, 2, 2, 2, 2, 3, 3, 4, 4};
        fi = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0};
        la = '{0, 1, 0, 1, 1, 1, 1, 0, 1, 0, 1};
        launch(1'b0, 1, 2);
        for (int c = 1; c <= 11; c++) begin
            stall = (c >= 4 && c <= 6);
            exp = {4'(st[c-1]), 4'd0, 1'(fi[c-1]), 1'(la[c-1]), 1'b1, 1'b0};
            obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
            checks++;
            if (obs !== exp)
                $display("FAIL stall cycle=%0d obs=%h exp=%h", c, obs, exp);
            else passes++;
            tick();
        end
        stall = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL stall_done cycle=12 done=%b busy=%b exp=1/0", done, busy);
        else passes++;
        tick();
    endtask

    task automatic test_zero_layers();
        logic [11:0] obs;
        launch(1'b1, 0, 4);
        obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
        checks++;
        if (obs !== 12'h001)
            $display("FAIL zero_layers_done obs=%h exp=%h", obs, 12'h001);
        else passes++;
        tick();
        obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
        checks++;
        if (obs !== 12'h000)
            $display("FAIL zero_layers_idle obs=%h exp=%h", obs, 12'h000);
        else passes++;
    endtask

    task automatic test_start_while_busy();
        logic [11:0] obs, exp;
        int seen_busy;
        launch(1'b0, 1, 1);
        for (int c = 1; c <= 4; c++) begin
            // Conflicting request mid-run must be dropped.
            if (c == 2) begin
                start = 1'b1; mode = 1'b1; num_layers = 4'd3; beats = 8'd5;
            end else begin
                start = 1'b0;
            end
            exp = {4'(c), 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
            obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
            checks++;
            if (obs !== exp)
                $display("FAIL busy_start cycle=%0d obs=%h exp=%h", c, obs, exp);
            else passes++;
            tick();
        end
        // Cycle 5 is FIN; start here is dropped, accepted from cycle 6.
        start = 1'b1; mode = 1'b0; num_layers = 4'd1; beats = 8'd1;
        checks++;
        if (done !== 1'b1)
            $display("FAIL busy_start_done done=%b exp=1", done);
        else passes++;
        tick();
        checks++;
        if (busy !== 1'b0 || rd_stage !== 4'd0)
            $display("FAIL fin_start_ignored busy=%b stage=%0d exp=0/0", busy, rd_stage);
        else passes++;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_stage !== 4'd1 || layer_idx !== 4'd0)
            $display("FAIL idle_start_accept busy=%b stage=%0d layer=%0d exp=1/1/0",
                     busy, rd_stage, layer_idx);
        else passes++;
        // Bounded drain back to idle.
        seen_busy = 0;
        for (int i = 0; i < 20 && (busy || done); i++) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL drain_timeout busy=%b done=%b exp=0/0", busy, done);
        else passes++;
    endtask

    task automatic test_reset_mid_run();
        logic [11:0] obs;
        launch(1'b1, 2, 1);
        tick();
        tick();
        // Cycle 3: stage 3 of layer 0.
        checks++;
        if (rd_stage !== 4'd3 || layer_idx !== 4'd0)
            $display("FAIL pre_reset stage=%0d layer=%0d exp=3/0", rd_stage, layer_idx);
        else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
        checks++;
        if (obs !== 12'h000)
            $display("FAIL mid_reset obs=%h exp=%h", obs, 12'h000);
        else passes++;
        tick();
        obs = {rd_stage, layer_idx, stage_first, stage_last, busy, done};
        checks++;
        if (obs !== 12'h000)
            $display("FAIL mid_reset_no_done obs=%h exp=%h", obs, 12'h000);
        else passes++;
        test_training(1);
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_inference();
        test_training(1);
        test_training(0);
        test_stall();
        test_zero_layers();
        test_start_while_busy();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d passes=%0d", checks, passes);
        $fatal(1, "watchdog");
    end

endmodule
